// File: rtl/inst_mem_loader.sv
// Byte-serial instruction-memory loader: packs little-endian bytes into 32-bit words
// and writes them to consecutive word addresses. Optional checksum byte: LOADER_CHECKSUM_EN.
module inst_mem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Start,
    input  logic [ADDR_W:0]   Word_Count,
    input  logic [7:0]        Byte_In,
    input  logic              Byte_Valid,
    output logic              Byte_Ready,
    output logic              Mem_WE,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [31:0]       Mem_WData,
    output logic              Busy,
    output logic              Done,
    output logic              Error
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        WRITE  = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        CHECK  = 3'd4,
`endif
        FINISH = 3'd3
    } state_t;

    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] last_addr_reg;
    logic [1:0]        idx_reg;
    logic              err_reg;
    logic              wc_ok;
    logic              start_ok;
    logic              byte_acc;
    logic              last_word;

    assign wc_ok     = (Word_Count != '0) && (Word_Count <= MAX_WORDS);
    assign start_ok  = (state_reg == IDLE) && Start && wc_ok;
    assign byte_acc  = Byte_Valid && Byte_Ready;
    assign last_word = (addr_reg == last_addr_reg);

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_reg;
    logic       bad_reg;

    assign Byte_Ready = (state_reg == LOAD) || (state_reg == CHECK);
    assign Error      = err_reg || ((state_reg == FINISH) && bad_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg <= '0;
            bad_reg <= 1'b0;
        end else if (start_ok) begin
            sum_reg <= '0;
            bad_reg <= 1'b0;
        end else if (state_reg == LOAD && byte_acc) begin
            sum_reg <= sum_reg + Byte_In;
        end else if (state_reg == CHECK && byte_acc) begin
            bad_reg <= (Byte_In != sum_reg);
        end
    end
`else
    assign Byte_Ready = (state_reg == LOAD);
    assign Error      = err_reg;
`endif

    assign Mem_WE   = (state_reg == WRITE);
    assign Mem_Addr = addr_reg;
    assign Busy     = (state_reg != IDLE);
    assign Done     = (state_reg == FINISH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:   if (start_ok) state_next = LOAD;
            LOAD:   if (byte_acc && idx_reg == 2'd3) state_next = WRITE;
            WRITE: begin
                if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    state_next = CHECK;
`else
                    state_next = FINISH;
`endif
                end else begin
                    state_next = LOAD;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK:  if (byte_acc) state_next = FINISH;
`endif
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Address stops at the last word rather than stepping past it, so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg      <= '0;
            last_addr_reg <= '0;
            idx_reg       <= '0;
            err_reg       <= 1'b0;
        end else begin
            err_reg <= (state_reg == IDLE) && Start && !wc_ok;
            if (start_ok) begin
                addr_reg      <= '0;
                last_addr_reg <= ADDR_W'(Word_Count - (ADDR_W + 1)'(1));
                idx_reg       <= '0;
            end else if (state_reg == LOAD && byte_acc) begin
                idx_reg <= idx_reg + 2'd1;
            end else if (state_reg == WRITE && !last_word) begin
                addr_reg <= addr_reg + ADDR_W'(1);
            end
        end
    end

    // One byte lane per word position; lane gi captures the gi-th accepted byte.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lane_reg <= '0;
                end else if (state_reg == LOAD && byte_acc && idx_reg == 2'(gi)) begin
                    lane_reg <= Byte_In;
                end
            end

            assign Mem_WData[gi*8 +: 8] = lane_reg;
        end
    endgenerate

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: driver pushes expected writes/ends into a queue,
// a negedge monitor pops and compares whenever the loader writes, finishes or rejects.
module tb_inst_mem_loader;

    localparam int ADDR_W = 8;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              Start = 1'b0;
    logic [ADDR_W:0]   Word_Count = '0;
    logic [7:0]        Byte_In = '0;
    logic              Byte_Valid = 1'b0;
    logic              Byte_Ready;
    logic              Mem_WE;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [31:0]       Mem_WData;
    logic              Busy;
    logic              Done;
    logic              Error;

    inst_mem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .Word_Count(Word_Count),
        .Byte_In(Byte_In), .Byte_Valid(Byte_Valid), .Byte_Ready(Byte_Ready),
        .Mem_WE(Mem_WE), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
        .Busy(Busy), .Done(Done), .Error(Error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;   // 0 write, 1 session end, 2 rejected start
        int          addr;
        logic [31:0] data;
        bit          err;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] stim[$];
    int tests = 0;
    int fails = 0;
    int accept_cyc = 0;
    int last_we_cyc = 0;
    int done_cnt = 0;
    ev_t mon_e;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void unexpected(string what);
        tests++;
        fails++;
        $display("FAIL unexpected_%s: addr=%0d data=0x%08h err=%0b with empty scoreboard (cycle %0d)",
                 what, Mem_Addr, Mem_WData, Error, cyc);
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (Mem_WE) begin
                $display("[TB] write addr=%0d data=0x%08h", Mem_Addr, Mem_WData);
                if (exp_q.size() == 0) unexpected("write");
                else begin
                    mon_e = exp_q.pop_front();
                    check("write_kind", 32'(mon_e.kind), 32'd0);
                    check("write_addr", 32'(Mem_Addr), 32'(mon_e.addr));
                    check("write_data", Mem_WData, mon_e.data);
                    check("write_latency", 32'(cyc), 32'(accept_cyc));
                end
                last_we_cyc = cyc;
            end
            if (Done) begin
                $display("[TB] done error=%0b", Error);
                if (exp_q.size() == 0) unexpected("done");
                else begin
                    mon_e = exp_q.pop_front();
                    check("done_kind", 32'(mon_e.kind), 32'd1);
                    check("done_error", 32'(Error), 32'(mon_e.err));
`ifndef LOADER_CHECKSUM_EN
                    check("done_latency", 32'(cyc), 32'(last_we_cyc + 1));
`endif
                end
                done_cnt++;
            end
            if (Error && !Done) begin
                $display("[TB] rejected start error pulse");
                if (exp_q.size() == 0) unexpected("error");
                else begin
                    mon_e = exp_q.pop_front();
                    check("reject_kind", 32'(mon_e.kind), 32'd2);
                end
            end
        end
    end

    task automatic pulse_start(input int wc);
        @(negedge clk);
        Start = 1'b1;
        Word_Count = (ADDR_W + 1)'(wc);
        @(negedge clk);
        Start = 1'b0;
    endtask

    task automatic send_bytes(input int total, input int gap_pct, input int start_at);
        int  j = 0;
        int  budget = 0;
        bit  injected = 1'b0;
        while (j < total && budget < 20000) begin
            @(negedge clk);
            Start = 1'b0;
            budget++;
            if (start_at >= 0 && j == start_at && !injected) begin
                Start = 1'b1;
                Word_Count = (ADDR_W + 1)'(5);
                injected = 1'b1;
            end
            if ($urandom_range(99) < gap_pct) begin
                Byte_Valid = 1'b0;
                Byte_In = 8'($urandom);
            end else begin
                Byte_Valid = 1'b1;
                Byte_In = stim[j];
            end
            if (Byte_Valid && Byte_Ready) begin
                j++;
                accept_cyc = cyc + 1;
            end
        end
        check("bytes_accepted", 32'(j), 32'(total));
        @(negedge clk);
        Start = 1'b0;
        Byte_Valid = 1'b0;
    endtask

    // Reference: word i is bytes 4i..4i+3 little-endian at address i; checksum is the byte sum.
    task automatic run_session(input int n, input int gap_pct, input int start_at, input bit bad_chk);
        ev_t        e;
        logic [7:0] sum = 8'd0;
        int         total = 4 * n;
        int         base_done = done_cnt;
        for (int i = 0; i < n; i++) begin
            e.kind = 0;
            e.addr = i;
            e.data = {stim[4*i+3], stim[4*i+2], stim[4*i+1], stim[4*i]};
            e.err  = 1'b0;
            exp_q.push_back(e);
        end
        for (int k = 0; k < 4 * n; k++) sum = sum + stim[k];
        if (CHK_EN) begin
            stim.push_back(bad_chk ? (sum ^ 8'h01) : sum);
            total = total + 1;
        end
        e.kind = 1;
        e.addr = 0;
        e.data = '0;
        e.err  = bad_chk & CHK_EN;
        exp_q.push_back(e);
        $display("[TB] session words=%0d gap=%0d%% bad_chk=%0b", n, gap_pct, bad_chk & CHK_EN);
        pulse_start(n);
        send_bytes(total, gap_pct, start_at);
        for (int k = 0; k < 100 && done_cnt == base_done; k++) @(negedge clk);
        @(negedge clk);
        check("done_seen", 32'(done_cnt), 32'(base_done + 1));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("busy_after", 32'(Busy), 32'd0);
    endtask

    task automatic reject(input int wc);
        ev_t e;
        e.kind = 2;
        e.addr = 0;
        e.data = '0;
        e.err  = 1'b1;
        exp_q.push_back(e);
        $display("[TB] start with Word_Count=%0d", wc);
        pulse_start(wc);
        repeat (3) @(negedge clk);
        check("reject_busy", 32'(Busy), 32'd0);
        check("reject_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_ready"}, 32'(Byte_Ready), 32'd0);
        check({tag, "_we"},    32'(Mem_WE), 32'd0);
        check({tag, "_addr"},  32'(Mem_Addr), 32'd0);
        check({tag, "_wdata"}, Mem_WData, 32'd0);
        check({tag, "_busy"},  32'(Busy), 32'd0);
        check({tag, "_done"},  32'(Done), 32'd0);
        check({tag, "_error"}, 32'(Error), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single word, no gaps
        stim.delete();
        stim = {8'h13, 8'h00, 8'h00, 8'h00};
        run_session(1, 0, -1, 1'b0);

        // Two words with valid gaps
        stim.delete();
        stim = {8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
        run_session(2, 40, -1, 1'b0);

        // Out-of-range counts
        reject(0);
        reject(257);

        // Full memory with a Start injected mid-session
        stim.delete();
        for (int k = 0; k < 1024; k++) stim.push_back(8'($urandom));
        run_session(256, 10, 300, 1'b0);

        // Reset mid-word, then a fresh session rewrites address 0
        stim.delete();
        stim = {8'hA5, 8'h5A};
        $display("[TB] session aborted by reset after two bytes");
        pulse_start(1);
        send_bytes(2, 0, -1);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("midword_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        stim.delete();
        stim = {8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_session(1, 20, -1, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        stim.delete();
        stim = {8'h01, 8'h02, 8'h03, 8'h04};
        run_session(1, 0, -1, 1'b0);
        stim.delete();
        stim = {8'h01, 8'h02, 8'h03, 8'h04};
        run_session(1, 0, -1, 1'b1);
`endif

        // Randomized sessions
        for (int s = 0; s < 8; s++) begin
            int n;
            n = $urandom_range(1, 12);
            stim.delete();
            for (int k = 0; k < 4 * n; k++) stim.push_back(8'($urandom));
            run_session(n, $urandom_range(0, 60), -1, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        check("final_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader.md
INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning instruction-memory word-address width (256 words).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port Start  input  1  one-cycle request to begin a load session.
REQ-005 SHALL have port Word_Count  input  ADDR_W+1  number of 32-bit words to load, sampled on the accepted Start.
REQ-006 SHALL have port Byte_In  input  8  incoming program byte.
REQ-007 SHALL have port Byte_Valid  input  1  Byte_In is valid.
REQ-008 SHALL have port Byte_Ready  output  1  loader can accept a byte.
REQ-009 SHALL have port Mem_WE  output  1  one-cycle write strobe to instruction memory.
REQ-010 SHALL have port Mem_Addr  output  ADDR_W  word address being written.
REQ-011 SHALL have port Mem_WData  output  32  assembled instruction word.
REQ-012 SHALL have port Busy  output  1  session in progress.
REQ-013 SHALL have port Done  output  1  one-cycle pulse at session end.
REQ-014 SHALL have port Error  output  1  one-cycle pulse, coincident with Done or with a rejected Start.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, WRITE, CHECK, FINISH.
REQ-016 In IDLE, Start with 1 <= Word_Count <= 2^ADDR_W SHALL latch the count, clear the word address and byte index, and enter LOAD next cycle.
REQ-017 In IDLE, Start with Word_Count = 0 or > 2^ADDR_W SHALL pulse Error (no Done) next cycle and remain in IDLE.
REQ-018 Start while Busy SHALL be ignored.
REQ-019 Byte_Ready SHALL be 1 only in LOAD, plus CHECK when configured; a byte is accepted when Byte_Valid and Byte_Ready are both 1 on a rising edge.
REQ-020 Bytes SHALL be assembled little-endian: first accepted byte -> Mem_WData[7:0], fourth -> [31:24].
REQ-021 Acceptance of the fourth byte SHALL move LOAD -> WRITE; in WRITE, Mem_WE=1 for exactly one cycle with stable Mem_Addr/Mem_WData; Byte_Ready=0.
REQ-022 From WRITE: if the word just written is the last -> CHECK (when configured) or FINISH; else increment Mem_Addr by 1 and return to LOAD.
REQ-023 Write latency SHALL be exactly one cycle from fourth-byte acceptance to Mem_WE high.
REQ-024 FINISH SHALL pulse Done for one cycle (plus Error if flagged) and return to IDLE.
REQ-025 Busy SHALL be 1 in every state except IDLE.
REQ-026 A full 256-word load SHALL end with Mem_Addr = 255; Mem_Addr SHALL never wrap within a session.
REQ-027 Byte_Valid without Byte_Ready SHALL be ignored; no byte is ever dropped or duplicated.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, Byte_Ready=0, Mem_WE=0, Mem_Addr=0, Mem_WData=0, Busy=0, Done=0, Error=0, clear checksum, at any time including mid-word and mid-WRITE.
REQ-029 After reset release, no write SHALL occur until a new accepted Start.

Configuration
REQ-030 Macro LOADER_CHECKSUM_EN defined: after the last WRITE, CHECK accepts one extra byte; if it differs from the 8-bit modular sum of all data bytes, Error pulses with Done; no retroactive undo of writes.
REQ-031 Macro LOADER_CHECKSUM_EN undefined: no CHECK state, no checksum byte consumed; last WRITE -> FINISH; Error only per REQ-017.

Verification
REQ-032 Start, Word_Count=1, bytes 13,00,00,00 -> one Mem_WE, Mem_Addr=0, Mem_WData=0x00000013, Done one cycle later (macro off).
REQ-033 Word_Count=2, bytes 93,00,10,00,13,01,20,00 with Byte_Valid gaps -> writes 0x00100093 @0 and 0x00200113 @1, no extra writes.
REQ-034 Start with Word_Count=0, then 257 -> Error pulse each, Done never, Busy stays 0.
REQ-035 Word_Count=256 -> 256 writes, last at Mem_Addr=255, then Done; Start mid-session ignored.
REQ-036 rst_n low after second byte of word 0 -> outputs reset immediately; new session rewrites address 0 with fresh bytes.
REQ-037 Macro on, Word_Count=1, bytes 01,02,03,04 then checksum 0x0A -> Done, no Error; checksum 0x0B -> Done with Error.
